ras_ctrl: RTL and testbench
===========================

RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of RAS entries.
REQ-002 The block SHALL have parameter INDEX, default 4, meaning the pointer width, equal to log2(DEPTH).
REQ-003 The block SHALL have parameter WIDTH, default 32, meaning the return-address width.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  the single clock.
- reset_n  in  1  asynchronous, active-low reset.
- specPush_i  in  1  fetch-side call.
- specPop_i  in  1  fetch-side return.
- specAddr_i  in  WIDTH  return address to push.
- specReady_o  out  1  fetch operations are accepted.
- archPush_i  in  1  commit-side call.
- archPop_i  in  1  commit-side return.
- archAddr_i  in  WIDTH  committed return address.
- archReady_o  out  1  commit operations are accepted.
- recover_i  in  1  mispredict or flush; restore the speculative stack.
- predAddr_o  out  WIDTH  predicted return address (RAM read data).
- predValid_o  out  1  the speculative stack is non-empty.
- ramRdAddr_o  out  INDEX  RAM read address.
- ramRdData_i  in  WIDTH  RAM read data.
- ramWrAddr0_o  out  INDEX  speculative write port address.
- ramWrData0_o  out  WIDTH  speculative write port data.
- ramWe0_o  out  1  speculative write port enable.
- ramWrAddr1_o  out  INDEX  architectural/checkpoint write port address.
- ramWrData1_o  out  WIDTH  architectural/checkpoint write port data.
- ramWe1_o  out  1  architectural/checkpoint write port enable.
- ramRecover_o  out  1  copy the checkpoint into the RAM at the next edge.
- specCount_o  out  INDEX+1  number of speculative entries.
- archCount_o  out  INDEX+1  number of architectural entries.

Function
REQ-005 The block SHALL hold the state registers specTos, archTos (INDEX bits each), specCnt, archCnt (INDEX+1 bits each) and an FSM with states RUN and RECOVER.
REQ-006 A TOS pointer SHALL address the top valid entry, and pointer arithmetic SHALL wrap modulo DEPTH.
REQ-007 ramRdAddr_o SHALL equal specTos, predAddr_o SHALL equal ramRdData_i combinationally, and predValid_o SHALL equal (specCnt != 0).
REQ-008 In RUN, specReady_o and archReady_o SHALL both be 1; in RECOVER, both SHALL be 0 and all push/pop inputs SHALL be ignored.
REQ-009 On a speculative push alone, the block SHALL drive ramWe0_o=1, ramWrAddr0_o=specTos+1 and ramWrData0_o=specAddr_i, then update specTos<=specTos+1 and specCnt<=min(specCnt+1, DEPTH); on overflow the oldest entry is overwritten.
REQ-010 On a speculative pop alone with specCnt>0, the block SHALL update specTos<=specTos-1 and specCnt<=specCnt-1.
REQ-011 On a speculative pop alone with specCnt==0, the block SHALL leave specTos and specCnt unchanged and issue no write.
REQ-012 On a simultaneous speculative push and pop, the block SHALL write specAddr_i at specTos, leave specTos unchanged, and set specCnt<=max(specCnt, 1).
REQ-013 Architectural push/pop SHALL follow REQ-009 to REQ-012 on archTos/archCnt, using write port 1 (ramWe1_o, ramWrAddr1_o, ramWrData1_o).
REQ-014 Speculative and architectural operations SHALL be processed independently in the same cycle.
REQ-015 A same-address collision between port 0 and port 1 SHALL be left to the RAM (port 1 wins), and the block SHALL NOT suppress either enable.
REQ-016 When recover_i=1 in RUN, speculative inputs SHALL be ignored that cycle, architectural inputs SHALL still be accepted and written, and the FSM SHALL go to RECOVER at the next edge.
REQ-017 In RECOVER, ramRecover_o SHALL be 1 and ramWe0_o and ramWe1_o SHALL be 0.
REQ-018 At the edge leaving RECOVER, the block SHALL load specTos<=archTos and specCnt<=archCnt, and the FSM SHALL return to RUN unconditionally.
REQ-019 recover_i asserted while in RECOVER SHALL be ignored.
REQ-020 Recovery latency SHALL be: recover_i at cycle T, RECOVER at T+1, RUN with the restored stack at T+2.
REQ-021 ramRecover_o SHALL be 0 in RUN, and write enables SHALL be 0 when no operation is accepted.

Reset
REQ-022 When reset_n=0, the block SHALL asynchronously clear specTos, archTos, specCnt and archCnt to 0 and set the FSM to RUN.
REQ-023 During reset, the outputs SHALL be: specReady_o=1, archReady_o=1, predValid_o=0, ramRecover_o=0, all write enables 0, counts 0.
REQ-024 Assertion of reset_n during RECOVER SHALL abort recovery immediately, with no pointer copy.

Verification
REQ-025 The bench SHALL apply specPush of A=0x100 then B=0x200 -> ramWe0_o at addresses 1 then 2; specCount_o=2; predAddr_o=0x200.
REQ-026 The bench SHALL apply 17 specPushes with DEPTH=16 -> specCount_o saturates at 16 and specTos wraps to 1; then a specPop with specCnt=0 after draining -> no pointer change and predValid_o=0.
REQ-027 The bench SHALL apply a simultaneous specPush 0x300 and specPop with specTos=2 -> write at address 2, specTos stays 2, count unchanged.
REQ-028 The bench SHALL apply archPush 0x100 and specPush 0x100, 0x200, then recover_i -> ramRecover_o=1 for exactly one cycle, both readys 0, then specCount_o=1 and predAddr_o=0x100.
REQ-029 The bench SHALL apply recover_i together with archPush 0x400 -> ramWe1_o=1 in the same cycle, and after RECOVER archCount_o equals specCount_o and predAddr_o=0x400.
REQ-030 The bench SHALL apply reset_n low mid-RECOVER -> all counts 0, FSM in RUN, ramRecover_o=0 with no clock edge required.

Source files
------------

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: speculative and architectural TOS/count
// tracking over an external two-write-port RAM, with checkpoint recovery.
module ras_ctrl #(
  parameter int DEPTH = 16,
  parameter int INDEX = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             specPush_i,
  input  logic             specPop_i,
  input  logic [WIDTH-1:0] specAddr_i,
  output logic             specReady_o,
  input  logic             archPush_i,
  input  logic             archPop_i,
  input  logic [WIDTH-1:0] archAddr_i,
  output logic             archReady_o,
  input  logic             recover_i,
  output logic [WIDTH-1:0] predAddr_o,
  output logic             predValid_o,
  output logic [INDEX-1:0] ramRdAddr_o,
  input  logic [WIDTH-1:0] ramRdData_i,
  output logic [INDEX-1:0] ramWrAddr0_o,
  output logic [WIDTH-1:0] ramWrData0_o,
  output logic             ramWe0_o,
  output logic [INDEX-1:0] ramWrAddr1_o,
  output logic [WIDTH-1:0] ramWrData1_o,
  output logic             ramWe1_o,
  output logic             ramRecover_o,
  output logic [INDEX:0]   specCount_o,
  output logic [INDEX:0]   archCount_o
);

  typedef enum logic {RUN, RECOVER} state_t;

  typedef struct packed {
    logic [INDEX-1:0] tos;
    logic [INDEX:0]   cnt;
  } stack_t;

  localparam logic [INDEX:0] FULL = (INDEX+1)'(DEPTH);

  state_t state;
  stack_t spec_q, arch_q, spec_d, arch_d;
  logic   run, spec_push, spec_pop, arch_push, arch_pop;

  // Pointer arithmetic wraps modulo DEPTH because DEPTH == 2**INDEX.
  function automatic stack_t stack_next(stack_t cur, logic push, logic pop);
    stack_t nxt;
    nxt = cur;
    if (push && pop) begin
      if (cur.cnt == '0) nxt.cnt = (INDEX+1)'(1);
    end else if (push) begin
      nxt.tos = cur.tos + 1'b1;
      if (cur.cnt != FULL) nxt.cnt = cur.cnt + 1'b1;
    end else if (pop && cur.cnt != '0) begin
      nxt.tos = cur.tos - 1'b1;
      nxt.cnt = cur.cnt - 1'b1;
    end
    return nxt;
  endfunction

  // Operations are only accepted in RUN and out of reset; a recover cycle
  // drops the speculative side but still commits architectural updates.
  assign run       = reset_n && (state == RUN);
  assign spec_push = run && !recover_i && specPush_i;
  assign spec_pop  = run && !recover_i && specPop_i;
  assign arch_push = run && archPush_i;
  assign arch_pop  = run && archPop_i;

  assign spec_d = stack_next(spec_q, spec_push, spec_pop);
  assign arch_d = stack_next(arch_q, arch_push, arch_pop);

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ramWe0_o     = 1'b0;
    ramWrAddr0_o = '0;
    ramWrData0_o = '0;
    ramWe1_o     = 1'b0;
    ramWrAddr1_o = '0;
    ramWrData1_o = '0;
    if (spec_push) begin
      ramWe0_o     = 1'b1;
      ramWrAddr0_o = spec_pop ? spec_q.tos : spec_q.tos + 1'b1;
      ramWrData0_o = specAddr_i;
    end
    if (arch_push) begin
      ramWe1_o     = 1'b1;
      ramWrAddr1_o = arch_pop ? arch_q.tos : arch_q.tos + 1'b1;
      ramWrData1_o = archAddr_i;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      spec_q <= '0;
      arch_q <= '0;
    end else begin
      arch_q <= arch_d;
      case (state)
        RUN: begin
          spec_q <= spec_d;
          if (recover_i) state <= RECOVER;
        end
        RECOVER: begin
          spec_q <= arch_q;
          state  <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign specReady_o  = (state == RUN);
  assign archReady_o  = (state == RUN);
  assign ramRecover_o = (state == RECOVER);
  assign ramRdAddr_o  = spec_q.tos;
  assign predAddr_o   = ramRdData_i;
  assign predValid_o  = (spec_q.cnt != '0);
  assign specCount_o  = spec_q.cnt;
  assign archCount_o  = arch_q.cnt;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl with a behavioural two-port RAM plus
// checkpoint copy feeding the read data back.
module tb_ras_ctrl;
  localparam int DEPTH = 16;
  localparam int INDEX = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             specPush_i, specPop_i, archPush_i, archPop_i, recover_i;
  logic [WIDTH-1:0] specAddr_i, archAddr_i;
  logic             specReady_o, archReady_o, predValid_o;
  logic [WIDTH-1:0] predAddr_o, ramRdData_i, ramWrData0_o, ramWrData1_o;
  logic [INDEX-1:0] ramRdAddr_o, ramWrAddr0_o, ramWrAddr1_o;
  logic             ramWe0_o, ramWe1_o, ramRecover_o;
  logic [INDEX:0]   specCount_o, archCount_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [WIDTH-1:0] mem  [DEPTH];
  logic [WIDTH-1:0] ckpt [DEPTH];

  always #5 clk = ~clk;

  ras_ctrl #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .specPush_i(specPush_i), .specPop_i(specPop_i), .specAddr_i(specAddr_i),
    .specReady_o(specReady_o),
    .archPush_i(archPush_i), .archPop_i(archPop_i), .archAddr_i(archAddr_i),
    .archReady_o(archReady_o),
    .recover_i(recover_i), .predAddr_o(predAddr_o), .predValid_o(predValid_o),
    .ramRdAddr_o(ramRdAddr_o), .ramRdData_i(ramRdData_i),
    .ramWrAddr0_o(ramWrAddr0_o), .ramWrData0_o(ramWrData0_o), .ramWe0_o(ramWe0_o),
    .ramWrAddr1_o(ramWrAddr1_o), .ramWrData1_o(ramWrData1_o), .ramWe1_o(ramWe1_o),
    .ramRecover_o(ramRecover_o),
    .specCount_o(specCount_o), .archCount_o(archCount_o)
  );

  // RAM model: port 1 wins on collision and also maintains the checkpoint.
  assign ramRdData_i = mem[ramRdAddr_o];
  always @(posedge clk) begin
    if (ramRecover_o) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ckpt[i];
    end else begin
      if (ramWe0_o) mem[ramWrAddr0_o] <= ramWrData0_o;
      if (ramWe1_o) mem[ramWrAddr1_o] <= ramWrData1_o;
    end
    if (ramWe1_o) ckpt[ramWrAddr1_o] <= ramWrData1_o;
  end

  task automatic idle();
    specPush_i = 0; specPop_i = 0; specAddr_i = '0;
    archPush_i = 0; archPop_i = 0; archAddr_i = '0;
    recover_i  = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset_n = 0;
    step();
    reset_n = 1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    specPush_i = 1; archPush_i = 1;
    #2;
    vec_cnt++;
    if (specReady_o !== 1 || archReady_o !== 1 || predValid_o !== 0 || ramRecover_o !== 0) begin
      err_cnt++;
      $display("FAIL reset_flags: srdy=%b ardy=%b pv=%b rec=%b, want 1 1 0 0",
               specReady_o, archReady_o, predValid_o, ramRecover_o);
    end
    vec_cnt++;
    if (ramWe0_o !== 0 || ramWe1_o !== 0 || specCount_o !== 0 || archCount_o !== 0) begin
      err_cnt++;
      $display("FAIL reset_we_cnt: we0=%b we1=%b sc=%0d ac=%0d, want 0 0 0 0",
               ramWe0_o, ramWe1_o, specCount_o, archCount_o);
    end
    step();
    reset_n = 1;
    idle();
    #1;
  endtask

  task automatic test_push_basic();
    apply_reset();
    specPush_i = 1; specAddr_i = 32'h100;
    #1;
    vec_cnt++;
    if (ramWe0_o !== 1 || ramWrAddr0_o !== 4'd1 || ramWrData0_o !== 32'h100) begin
      err_cnt++;
      $display("FAIL push_a: we0=%b addr=%0d data=%h, want 1 1 00000100",
               ramWe0_o, ramWrAddr0_o, ramWrData0_o);
    end
    step();
    specAddr_i = 32'h200;
    #1;
    vec_cnt++;
    if (ramWe0_o !== 1 || ramWrAddr0_o !== 4'd2 || ramWrData0_o !== 32'h200) begin
      err_cnt++;
      $display("FAIL push_b: we0=%b addr=%0d data=%h, want 1 2 00000200",
               ramWe0_o, ramWrAddr0_o, ramWrData0_o);
    end
    step();
    idle();
    #1;
    vec_cnt++;
    if (specCount_o !== 5'd2 || predAddr_o !== 32'h200 || predValid_o !== 1) begin
      err_cnt++;
      $display("FAIL push_result: cnt=%0d pred=%h pv=%b, want 2 00000200 1",
               specCount_o, predAddr_o, predValid_o);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      if (i == DEPTH) begin
        vec_cnt++;
        if (specCount_o !== 5'd16 || ramRdAddr_o !== 4'd0) begin
          err_cnt++;
          $display("FAIL full_16: cnt=%0d tos=%0d, want 16 0", specCount_o, ramRdAddr_o);
        end
      end
      specPush_i = 1; specAddr_i = 32'h1000 + i;
      step();
    end
    idle();
    #1;
    vec_cnt++;
    if (specCount_o !== 5'd16 || ramRdAddr_o !== 4'd1 || predAddr_o !== 32'h1010) begin
      err_cnt++;
      $display("FAIL overflow_17: cnt=%0d tos=%0d pred=%h, want 16 1 00001010",
               specCount_o, ramRdAddr_o, predAddr_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      specPop_i = 1;
      step();
    end
    idle();
    #1;
    vec_cnt++;
    if (specCount_o !== 0 || predValid_o !== 0 || ramRdAddr_o !== 4'd1) begin
      err_cnt++;
      $display("FAIL drained: cnt=%0d pv=%b tos=%0d, want 0 0 1",
               specCount_o, predValid_o, ramRdAddr_o);
    end
    specPop_i = 1;
    #1;
    vec_cnt++;
    if (ramWe0_o !== 0) begin
      err_cnt++;
      $display("FAIL empty_pop_we: we0=%b, want 0", ramWe0_o);
    end
    step();
    idle();
    #1;
    vec_cnt++;
    if (specCount_o !== 0 || predValid_o !== 0 || ramRdAddr_o !== 4'd1) begin
      err_cnt++;
      $display("FAIL empty_pop: cnt=%0d pv=%b tos=%0d, want 0 0 1",
               specCount_o, predValid_o, ramRdAddr_o);
    end
  endtask

  task automatic test_push_pop();
    apply_reset();
    specPush_i = 1; specAddr_i = 32'h10;
    step();
    specAddr_i = 32'h20;
    step();
    specPop_i = 1; specAddr_i = 32'h300;
    #1;
    vec_cnt++;
    if (ramWe0_o !== 1 || ramWrAddr0_o !== 4'd2 || ramWrData0_o !== 32'h300) begin
      err_cnt++;
      $display("FAIL pushpop_write: we0=%b addr=%0d data=%h, want 1 2 00000300",
               ramWe0_o, ramWrAddr0_o, ramWrData0_o);
    end
    step();
    idle();
    #1;
    vec_cnt++;
    if (ramRdAddr_o !== 4'd2 || specCount_o !== 5'd2 || predAddr_o !== 32'h300) begin
      err_cnt++;
      $display("FAIL pushpop_state: tos=%0d cnt=%0d pred=%h, want 2 2 00000300",
               ramRdAddr_o, specCount_o, predAddr_o);
    end
    apply_reset();
    specPush_i = 1; specPop_i = 1; specAddr_i = 32'h77;
    #1;
    vec_cnt++;
    if (ramWe0_o !== 1 || ramWrAddr0_o !== 4'd0) begin
      err_cnt++;
      $display("FAIL pushpop_empty_write: we0=%b addr=%0d, want 1 0", ramWe0_o, ramWrAddr0_o);
    end
    step();
    idle();
    #1;
    vec_cnt++;
    if (specCount_o !== 5'd1 || ramRdAddr_o !== 4'd0 || predAddr_o !== 32'h77) begin
      err_cnt++;
      $display("FAIL pushpop_empty_state: cnt=%0d tos=%0d pred=%h, want 1 0 00000077",
               specCount_o, ramRdAddr_o, predAddr_o);
    end
  endtask

  task automatic test_recover();
    apply_reset();
    archPush_i = 1; archAddr_i = 32'h100;
    specPush_i = 1; specAddr_i = 32'h100;
    #1;
    vec_cnt++;
    if (ramWe0_o !== 1 || ramWe1_o !== 1 || ramWrAddr0_o !== 4'd1 || ramWrAddr1_o !== 4'd1) begin
      err_cnt++;
      $display("FAIL collision: we0=%b we1=%b a0=%0d a1=%0d, want 1 1 1 1",
               ramWe0_o, ramWe1_o, ramWrAddr0_o, ramWrAddr1_o);
    end
    step();
    archPush_i = 0; specAddr_i = 32'h200;
    step();
    recover_i = 1; specAddr_i = 32'hdead;
    #1;
    vec_cnt++;
    if (ramWe0_o !== 0 || specReady_o !== 1 || ramRecover_o !== 0) begin
      err_cnt++;
      $display("FAIL recover_req: we0=%b srdy=%b rec=%b, want 0 1 0",
               ramWe0_o, specReady_o, ramRecover_o);
    end
    step();
    specPush_i = 1; archPush_i = 1; specPop_i = 1;
    #1;
    vec_cnt++;
    if (ramRecover_o !== 1 || specReady_o !== 0 || archReady_o !== 0 ||
        ramWe0_o !== 0 || ramWe1_o !== 0) begin
      err_cnt++;
      $display("FAIL in_recover: rec=%b srdy=%b ardy=%b we0=%b we1=%b, want 1 0 0 0 0",
               ramRecover_o, specReady_o, archReady_o, ramWe0_o, ramWe1_o);
    end
    step();
    idle();
    #1;
    vec_cnt++;
    if (ramRecover_o !== 0 || specReady_o !== 1 || archReady_o !== 1 ||
        specCount_o !== 5'd1 || archCount_o !== 5'd1 || predAddr_o !== 32'h100) begin
      err_cnt++;
      $display("FAIL recovered: rec=%b srdy=%b ardy=%b sc=%0d ac=%0d pred=%h, want 0 1 1 1 1 00000100",
               ramRecover_o, specReady_o, archReady_o, specCount_o, archCount_o, predAddr_o);
    end
  endtask

  task automatic test_recover_arch();
    specPush_i = 1; specAddr_i = 32'h500;
    step();
    recover_i = 1; archPush_i = 1; archAddr_i = 32'h400;
    #1;
    vec_cnt++;
    if (ramWe1_o !== 1 || ramWrAddr1_o !== 4'd2 || ramWrData1_o !== 32'h400 || ramWe0_o !== 0) begin
      err_cnt++;
      $display("FAIL recover_arch_write: we1=%b a1=%0d d1=%h we0=%b, want 1 2 00000400 0",
               ramWe1_o, ramWrAddr1_o, ramWrData1_o, ramWe0_o);
    end
    step();
    idle();
    step();
    #1;
    vec_cnt++;
    if (archCount_o !== 5'd2 || specCount_o !== 5'd2 || predAddr_o !== 32'h400 || specReady_o !== 1) begin
      err_cnt++;
      $display("FAIL recover_arch_state: ac=%0d sc=%0d pred=%h srdy=%b, want 2 2 00000400 1",
               archCount_o, specCount_o, predAddr_o, specReady_o);
    end
  endtask

  task automatic test_reset_in_recover();
    archPush_i = 1; archAddr_i = 32'h600;
    step();
    archPush_i = 0; recover_i = 1;
    step();
    idle();
    #1;
    vec_cnt++;
    if (ramRecover_o !== 1) begin
      err_cnt++;
      $display("FAIL pre_abort: rec=%b, want 1", ramRecover_o);
    end
    reset_n = 0;
    #1;
    vec_cnt++;
    if (ramRecover_o !== 0 || specReady_o !== 1 || specCount_o !== 0 ||
        archCount_o !== 0 || predValid_o !== 0) begin
      err_cnt++;
      $display("FAIL abort_async: rec=%b srdy=%b sc=%0d ac=%0d pv=%b, want 0 1 0 0 0",
               ramRecover_o, specReady_o, specCount_o, archCount_o, predValid_o);
    end
    reset_n = 1;
    step();
    vec_cnt++;
    if (ramRecover_o !== 0 || specCount_o !== 0 || archReady_o !== 1) begin
      err_cnt++;
      $display("FAIL abort_after: rec=%b sc=%0d ardy=%b, want 0 0 1",
               ramRecover_o, specCount_o, archReady_o);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      ckpt[i] = '0;
    end
    test_reset();
    test_push_basic();
    test_overflow();
    test_push_pop();
    test_recover();
    test_recover_arch();
    test_reset_in_recover();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
